pipelined_addsub: RTL
=====================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 16: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 Derived constant STAGES = WIDTH/CHUNK: pipeline depth in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 sub  input  1  1 = a-b, 0 = a+b.
REQ-011 sat  input  1  1 = signed saturating result, 0 = modular wrap.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  unsigned carry out of MSB (for sub: 1 = no borrow, a >= b unsigned).
REQ-016 ovf  output  1  signed two's-complement overflow of the unsaturated result.

Function
REQ-017 Beat transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-018 Pipeline enable en = !out_valid || out_ready; in_ready SHALL equal en (global stall, combinational from out_valid/out_ready only).
REQ-019 When en=0 all stage registers, including out_valid, sum, cout, ovf, SHALL hold.
REQ-020 Operation: b' = b XOR {WIDTH{sub}}, carry-in to chunk 0 = sub; result = a + b' + sub mod 2^WIDTH.
REQ-021 Stage k (0..STAGES-1) SHALL add chunk k of a and b' with the carry registered from stage k-1, registering the chunk sum and carry out; higher operand chunks and sub/sat SHALL be delayed so each beat's chunks stay aligned.
REQ-022 Latency SHALL be exactly STAGES enabled cycles from input transfer to out_valid; throughput one beat per cycle when out_ready stays 1.
REQ-023 Each stage SHALL carry a valid bit; a cycle with en=1 and in_valid=0 inserts a bubble; bubbles SHALL never produce out_valid=1.
REQ-024 cout = carry out of the final chunk; ovf = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]), raw = unsaturated result.
REQ-025 sat=1 and ovf=1: sum SHALL be 2^(WIDTH-1)-1 if a[MSB]=0, else 2^(WIDTH-1); otherwise sum = raw; cout and ovf SHALL report the raw computation regardless of sat.
REQ-026 sub and sat SHALL be sampled per beat at input transfer; changes between beats SHALL not affect in-flight beats.
REQ-027 Results SHALL emerge in acceptance order; no beat dropped or duplicated under any out_ready pattern.
REQ-028 STAGES=1 (CHUNK=WIDTH) SHALL yield a single-register pipeline, latency 1, same handshake.
REQ-029 out_valid, sum, cout, ovf SHALL be driven only from registers.

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf to 0 without waiting for clk.
REQ-031 Beats in flight at reset assertion SHALL be discarded; first beat accepted after rst_n deasserts SHALL appear STAGES enabled cycles later.
REQ-032 in_ready SHALL be 1 during and immediately after reset (out_valid=0).

Verification
REQ-033 WIDTH=32, CHUNK=16, out_ready=1: a=0x0000FFFF, b=0x00000001, sub=0 -> after 2 cycles sum=0x00010000, cout=0, ovf=0 (cross-chunk carry).
REQ-034 sub=1, a=5, b=7, sat=0 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1, sat=1 -> sum=0x80000000, ovf=1; sat=0 -> sum=0x7FFFFFFF, ovf=1.
REQ-035 sat=1, a=0x7FFFFFFF, b=1, sub=0 -> sum=0x7FFFFFFF, ovf=1, cout=0.
REQ-036 Stream 100 random beats with random in_valid and out_ready (50%) -> results match reference model in order, none lost, outputs stable while out_valid && !out_ready.
REQ-037 Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 same cycle, no stale beat after release; next beat correct with latency 2.
REQ-038 Repeat REQ-033/REQ-036 with WIDTH=64, CHUNK=8 (latency 8) and WIDTH=8, CHUNK=8 (latency 1).

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with optional signed saturation.
// The WIDTH-bit operation is split into STAGES = WIDTH/CHUNK ripple stages.
// Each stage adds one CHUNK and registers its carry for the next stage.
// A single global enable stalls the whole pipe whenever the output is
// held. The result therefore appears exactly STAGES enabled cycles after
// input acceptance.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake (in_ready = pipeline enable)
//   a, b                operands
//   sub                 1 = a-b, 0 = a+b (sampled per beat)
//   sat                 1 = signed saturating result (sampled per beat)
//   out_valid/out_ready result beat handshake
//   sum                 result (saturated when sat=1 and overflow)
//   cout                unsigned carry out of MSB (sub: 1 = no borrow)
//   ovf                 signed overflow of the unsaturated result
module pipelined_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned MSB    = WIDTH - 1;
  // Inter-stage register count; at least one entry so the arrays stay legal.
  localparam int unsigned PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  logic en;

  // Inter-stage registers: entry k holds the output of stage k.
  logic             vld_q [PIPE];
  logic             cry_q [PIPE];
  logic             sat_q [PIPE];
  logic [WIDTH-1:0] a_q   [PIPE];
  logic [WIDTH-1:0] bx_q  [PIPE];
  logic [WIDTH-1:0] raw_q [PIPE];

  // Stage inputs: entry 0 comes from the ports, entry k from register k-1.
  logic             si_v   [STAGES];
  logic             si_c   [STAGES];
  logic             si_sat [STAGES];
  logic [WIDTH-1:0] si_a   [STAGES];
  logic [WIDTH-1:0] si_bx  [STAGES];
  logic [WIDTH-1:0] si_raw [STAGES];

  // Per-stage chunk sum with carry, and partial result with this chunk merged.
  logic [CHUNK:0]   cs     [STAGES];
  logic [WIDTH-1:0] raw_n  [STAGES];

  // Output registers.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Final-stage combinational results.
  logic [WIDTH-1:0] raw_fin;
  logic             a_msb;
  logic             bx_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_d;

  // Global stall: everything advances only when the output slot can move.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Subtraction is a + ~b + 1; the +1 enters as carry-in of chunk 0.
  assign si_v[0]   = in_valid;
  assign si_c[0]   = sub;
  assign si_sat[0] = sat;
  assign si_a[0]   = a;
  assign si_bx[0]  = b ^ {WIDTH{sub}};
  assign si_raw[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign si_v[k]   = vld_q[k-1];
    assign si_c[k]   = cry_q[k-1];
    assign si_sat[k] = sat_q[k-1];
    assign si_a[k]   = a_q[k-1];
    assign si_bx[k]  = bx_q[k-1];
    assign si_raw[k] = raw_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = k * CHUNK;

    // Chunk k add using the carry from the previous stage.
    assign cs[k] = {1'b0, si_a[k][LSB +: CHUNK]}
                 + {1'b0, si_bx[k][LSB +: CHUNK]}
                 + (CHUNK+1)'(si_c[k]);

    // Merge this chunk into the partial result; lower chunks are already final.
    assign raw_n[k] = (si_raw[k] & ~(WIDTH'({CHUNK{1'b1}}) << LSB))
                    | (WIDTH'(cs[k][CHUNK-1:0]) << LSB);

    if (k < LAST) begin : g_reg
      // Operands travel whole so later chunks stay aligned with their beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[k] <= 1'b0;
          cry_q[k] <= 1'b0;
          sat_q[k] <= 1'b0;
          a_q[k]   <= '0;
          bx_q[k]  <= '0;
          raw_q[k] <= '0;
        end else if (en) begin
          vld_q[k] <= si_v[k];
          cry_q[k] <= cs[k][CHUNK];
          sat_q[k] <= si_sat[k];
          a_q[k]   <= si_a[k];
          bx_q[k]  <= si_bx[k];
          raw_q[k] <= raw_n[k];
        end
      end
    end
  end

  // Overflow: operands of equal sign produce a result of the other sign.
  assign raw_fin = raw_n[LAST];
  assign a_msb   = si_a[LAST][MSB];
  assign bx_msb  = si_bx[LAST][MSB];
  assign ovf_d   = (a_msb == bx_msb) && (raw_fin[MSB] != a_msb);

  // Saturate toward the sign of a, which is the sign of the true result.
  always_comb begin
    sum_d = raw_fin;
    if (si_sat[LAST] && ovf_d) begin
      sum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Last stage writes straight into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= si_v[LAST];
      sum_q       <= sum_d;
      cout_q      <= cs[LAST][CHUNK];
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
